// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and parameter defaults for the SRAM controller
package sram_pkg;
    localparam int def_adr_width   = 18;
    localparam int def_dat_width   = 16;
    localparam int def_wait_states = 2;
    typedef enum logic [2:0] {IDLE, RD, WR, WREC, DONE} state_t;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request host bus to asynchronous SRAM controller with programmable strobe wait states
// ports: clk/reset; host stb, we, adr, sel, dat_w -> dat_r, ack;
//        SRAM sram_adr, sram_dat_o/sram_dat_i/sram_dat_oe (split tristate), sram_cs_n, sram_oe_n, sram_we_n, sram_be_n
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int adr_width   = def_adr_width,
    parameter int dat_width   = def_dat_width,
    parameter int wait_states = def_wait_states
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stb,
    input  logic                   we,
    input  logic [adr_width-1:0]   adr,
    input  logic [dat_width/8-1:0] sel,
    input  logic [dat_width-1:0]   dat_w,
    output logic [dat_width-1:0]   dat_r,
    output logic                   ack,
    output logic [adr_width-1:0]   sram_adr,
    output logic [dat_width-1:0]   sram_dat_o,
    input  logic [dat_width-1:0]   sram_dat_i,
    output logic                   sram_dat_oe,
    output logic                   sram_cs_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [dat_width/8-1:0] sram_be_n
);
    state_t     state;
    logic [3:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ack         <= 1'b0;
            dat_r       <= '0;
            sram_adr    <= '0;
            sram_dat_o  <= '0;
            sram_dat_oe <= 1'b0;
            sram_cs_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_be_n   <= '1;
        end else begin
            case (state)
                IDLE: if (stb) begin
                    sram_adr    <= adr;
                    sram_dat_o  <= dat_w;
                    sram_be_n   <= ~sel;
                    sram_cs_n   <= 1'b0;
                    sram_oe_n   <= we;
                    sram_we_n   <= ~we;
                    sram_dat_oe <= we;
                    cnt         <= 4'(wait_states);
                    state       <= we ? WR : RD;
                end
                RD: if (cnt == 0) begin
                    dat_r     <= sram_dat_i;
                    sram_cs_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_be_n <= '1;
                    ack       <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                WR: if (cnt == 0) begin
                    sram_we_n <= 1'b1;
                    state     <= WREC;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                // write-recovery cycle: we_n already high, address/data still driven for hold time
                WREC: begin
                    sram_cs_n   <= 1'b1;
                    sram_dat_oe <= 1'b0;
                    sram_be_n   <= '1;
                    ack         <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl with behavioural SRAM models
module tb_sram_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        stb0 = 0, we0 = 0, ack0, doe0, cs0, oe0, wen0;
    logic [17:0] adr0 = '0, sa0;
    logic [1:0]  sel0 = '0, be0;
    logic [15:0] dw0 = '0, dr0, so0, si0;
    logic [15:0] mem0 [256];

    sram_ctrl #(.adr_width(18), .dat_width(16), .wait_states(2)) u0 (
        .clk(clk), .reset(reset), .stb(stb0), .we(we0), .adr(adr0), .sel(sel0), .dat_w(dw0),
        .dat_r(dr0), .ack(ack0), .sram_adr(sa0), .sram_dat_o(so0), .sram_dat_i(si0),
        .sram_dat_oe(doe0), .sram_cs_n(cs0), .sram_oe_n(oe0), .sram_we_n(wen0), .sram_be_n(be0));

    assign si0 = (!cs0 && !oe0) ? mem0[sa0[7:0]] : '0;
    always @(posedge clk)
        if (!cs0 && !wen0)
            for (int b = 0; b < 2; b++)
                if (!be0[b]) mem0[sa0[7:0]][8*b+:8] <= so0[8*b+:8];

    logic        stb1 = 0, we1 = 0, ack1, doe1, cs1, oe1, wen1;
    logic [17:0] adr1 = '0, sa1;
    logic [3:0]  sel1 = '0, be1;
    logic [31:0] dw1 = '0, dr1, so1, si1;
    logic [31:0] mem1 [256];

    sram_ctrl #(.adr_width(18), .dat_width(32), .wait_states(0)) u1 (
        .clk(clk), .reset(reset), .stb(stb1), .we(we1), .adr(adr1), .sel(sel1), .dat_w(dw1),
        .dat_r(dr1), .ack(ack1), .sram_adr(sa1), .sram_dat_o(so1), .sram_dat_i(si1),
        .sram_dat_oe(doe1), .sram_cs_n(cs1), .sram_oe_n(oe1), .sram_we_n(wen1), .sram_be_n(be1));

    assign si1 = (!cs1 && !oe1) ? mem1[sa1[7:0]] : '0;
    always @(posedge clk)
        if (!cs1 && !wen1)
            for (int b = 0; b < 4; b++)
                if (!be1[b]) mem1[sa1[7:0]][8*b+:8] <= so1[8*b+:8];

    always @(negedge clk) begin
        chk("excl0", {62'd0, ~oe0 & ~wen0, ~oe0 & doe0}, 64'd0);
        chk("excl1", {62'd0, ~oe1 & ~wen1, ~oe1 & doe1}, 64'd0);
    end

    task automatic xfer(input int u, input bit w, input logic [17:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit drop,
                        output int lat, output int wel, output bit be_ones);
        if (u == 0) begin stb0 = 1; we0 = w; adr0 = a; dw0 = d[15:0]; sel0 = s[1:0]; end
        else        begin stb1 = 1; we1 = w; adr1 = a; dw1 = d;       sel1 = s;      end
        lat = 0; wel = 0; be_ones = 1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (drop && lat == 1) begin stb0 = 0; stb1 = 0; end
            if ((u == 0) ? !wen0 : !wen1) wel++;
            if ((u == 0) ? (be0 != 2'b11) : (be1 != 4'hF)) be_ones = 0;
        end while (!((u == 0) ? ack0 : ack1) && lat < 40);
        stb0 = 0; stb1 = 0;
        @(posedge clk); #1;
        chk("ack_pulse", {63'd0, (u == 0) ? ack0 : ack1}, 64'd0);
    endtask

    int lat, wel, k, e;
    bit bo;
    logic [31:0] exp_d;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {63'd0, ack0}, 0);
        chk("rst_ctl", {59'd0, cs0, oe0, wen0, doe0, 1'b0}, {59'd0, 5'b11100});
        chk("rst_be", {62'd0, be0}, 64'h3);
        chk("rst_adr", {46'd0, sa0}, 0);
        chk("rst_dato", {48'd0, so0}, 0);
        chk("rst_datr", {48'd0, dr0}, 0);
        chk("rst_ctl1", {56'd0, cs1, oe1, wen1, doe1, be1}, {56'd0, 8'b1110_1111});
        reset = 0;
        @(posedge clk); #1;

        xfer(0, 1, 18'h00010, 32'hBEEF, 4'h3, 0, lat, wel, bo);
        chk("wr_lat", lat, 5);
        chk("wr_wen_cycles", wel, 3);
        xfer(0, 0, 18'h00010, 0, 4'h3, 0, lat, wel, bo);
        chk("rd_lat", lat, 4);
        chk("rd_wen_cycles", wel, 0);
        chk("rd_data", {48'd0, dr0}, 64'hBEEF);

        xfer(0, 1, 18'h5, 32'h1234, 4'h3, 0, lat, wel, bo);
        xfer(0, 1, 18'h5, 32'hAB55, 4'h1, 0, lat, wel, bo);
        xfer(0, 0, 18'h5, 0, 4'h3, 0, lat, wel, bo);
        chk("byte_merge", {48'd0, dr0}, 64'h1255);

        xfer(0, 1, 18'h7, 32'h7777, 4'h3, 1, lat, wel, bo);
        chk("drop_lat", lat, 5);
        chk("datr_hold", {48'd0, dr0}, 64'h1255);
        xfer(0, 0, 18'h7, 0, 4'h3, 0, lat, wel, bo);
        chk("drop_data", {48'd0, dr0}, 64'h7777);

        stb0 = 1; we0 = 1; adr0 = 18'h20; dw0 = 16'hDEAD; sel0 = 2'b11;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_we", {63'd0, wen0}, 0);
        #2 reset = 1;
        #1;
        chk("arst_ctl", {58'd0, cs0, oe0, wen0, doe0, ack0, 1'b0}, {58'd0, 6'b111000});
        chk("arst_be", {62'd0, be0}, 64'h3);
        stb0 = 0;
        @(posedge clk); #1;
        reset = 0;
        k = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack0) k++;
        end
        chk("no_ack_after_rst", k, 0);
        xfer(0, 0, 18'h00010, 0, 4'h3, 0, lat, wel, bo);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_data", {48'd0, dr0}, 64'hBEEF);

        for (int i = 0; i < 8; i++) begin
            xfer(1, 1, 18'(i), 32'hC0DE0000 + 32'(i) * 32'h1111, 4'hF, 0, lat, wel, bo);
            if (i == 0) chk("wr32_lat", lat, 3);
        end
        stb1 = 1; we1 = 0; sel1 = 4'hF; adr1 = 0;
        k = 0; e = 0;
        while (k < 8 && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (ack1) begin
                chk("b2b_time", e, 2 + 3 * k);
                exp_d = 32'hC0DE0000 + 32'(k) * 32'h1111;
                chk("b2b_data", {32'd0, dr1}, {32'd0, exp_d});
                k++;
                adr1 = 18'(k);
            end
        end
        stb1 = 0;
        chk("b2b_count", k, 8);
        @(posedge clk); #1;

        xfer(1, 1, 18'h3, 32'hFFFFFFFF, 4'h0, 0, lat, wel, bo);
        chk("sel0_lat", lat, 3);
        chk("sel0_be_ones", {63'd0, bo}, 1);
        xfer(1, 0, 18'h3, 0, 4'hF, 0, lat, wel, bo);
        chk("sel0_mem", {32'd0, dr1}, 64'hC0DE3333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
